// File: rtl/video_rd_scheduler.sv
// Frame-read controller: keeps the HDMI line FIFO topped up with burst reads from
// frame memory and ping-pongs between two frame buffers on writer completion.
module video_rd_scheduler #(
  parameter int H_DISP     = 1280,
  parameter int V_DISP     = 800,
  parameter int BURST_LEN  = 64,
  parameter int FIFO_DEPTH = 512,
  parameter int ADDR_W     = 24,
  parameter logic [ADDR_W-1:0] FRAME_BASE0 = ADDR_W'(24'h000000),
  parameter logic [ADDR_W-1:0] FRAME_BASE1 = ADDR_W'(24'h100000)
) (
  input  logic              pixel_clk,
  input  logic              sys_rst_n,
  input  logic              video_vs,
  input  logic              data_req,
  input  logic [9:0]        fifo_level,
  input  logic              frame_done_wr,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_len,
  input  logic              rd_ack,
  input  logic              rd_done,
  output logic              fifo_clr,
  output logic              rd_bank,
  output logic              underflow
);

  typedef enum logic [2:0] {IDLE, CLR, CHECK, REQ, WAIT} state_t;

  localparam logic [20:0] FRAME_WORDS = 21'(H_DISP * V_DISP);
  localparam logic [20:0] BURST_W     = 21'(BURST_LEN);
  localparam logic [10:0] LEVEL_MAX   = 11'(FIFO_DEPTH - BURST_LEN);

  state_t             state;
  state_t             next_state;
  logic               vs_q;
  logic               vs_fall;
  logic               restart_pend;
  logic               swap_pend;
  logic [ADDR_W-1:0]  addr;
  logic [20:0]        words_left;
  logic [7:0]         next_len;
  logic               level_ok;

  // Only one burst is ever outstanding, so the raw FIFO level is a safe room check.
  assign vs_fall  = vs_q & ~video_vs;
  assign level_ok = ({1'b0, fifo_level} <= LEVEL_MAX);
  assign next_len = (words_left < BURST_W) ? words_left[7:0] : BURST_W[7:0];
  assign rd_req   = (state == REQ);
  assign fifo_clr = (state == CLR);

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (restart_pend) next_state = CLR;
      CLR:   next_state = CHECK;
      CHECK: begin
        if (restart_pend)          next_state = CLR;
        else if (words_left == '0) next_state = IDLE;
        else if (level_ok)         next_state = REQ;
      end
      REQ:   if (rd_ack)  next_state = WAIT;
      WAIT:  if (rd_done) next_state = CHECK;
      default: next_state = IDLE;
    endcase
  end

  // A new sync or writer pulse landing in the CLR cycle re-arms its pending flag.
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vs_q         <= 1'b0;
      restart_pend <= 1'b0;
      swap_pend    <= 1'b0;
      addr         <= FRAME_BASE0;
      words_left   <= '0;
      rd_addr      <= '0;
      rd_len       <= '0;
      rd_bank      <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      vs_q         <= video_vs;
      restart_pend <= vs_fall | (restart_pend & (state != CLR));
      swap_pend    <= frame_done_wr | (swap_pend & (state != CLR));
      if (state == CLR)
        underflow <= 1'b0;
      else if (data_req && (fifo_level == 10'd0))
        underflow <= 1'b1;
      case (state)
        CLR: begin
          if (swap_pend) begin
            rd_bank <= ~rd_bank;
            addr    <= rd_bank ? FRAME_BASE0 : FRAME_BASE1;
          end else begin
            addr    <= rd_bank ? FRAME_BASE1 : FRAME_BASE0;
          end
          words_left <= FRAME_WORDS;
        end
        CHECK: begin
          if (!restart_pend && (words_left != '0) && level_ok) begin
            rd_addr <= addr;
            rd_len  <= next_len;
          end
        end
        REQ: begin
          if (rd_ack) begin
            addr       <= addr + ADDR_W'(rd_len);
            words_left <= words_left - 21'(rd_len);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/video_rd_scheduler.md
Name: video_rd_scheduler

Overview:
- Frame-read controller feeding the HDMI display path's pixel line FIFO from frame memory.
- Watches the display timing generator's field sync and pixel request.
- Issues burst read requests to the memory arbiter, keeping the FIFO topped up ahead of consumption.
- Ping-pongs between two frame buffers when the writer signals a finished frame.

Parameters:
- H_DISP, 1280, active pixels per line.
- V_DISP, 800, active lines per frame.
- BURST_LEN, 64, maximum words per read burst (1..255).
- FIFO_DEPTH, 512, line FIFO capacity in words.
- ADDR_W, 24, memory word-address width.
- FRAME_BASE0, 24'h000000, word address of buffer 0.
- FRAME_BASE1, 24'h100000, word address of buffer 1.

Ports:
- pixel_clk  in  1  sole clock, rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- video_vs  in  1  field sync from timing generator, low during sync.
- data_req  in  1  pixel pop request, one word per cycle.
- fifo_level  in  10  current line-FIFO word count.
- frame_done_wr  in  1  one-cycle pulse: writer completed a frame.
- rd_req  out  1  burst read request to arbiter.
- rd_addr  out  ADDR_W  burst start word address.
- rd_len  out  8  burst length in words.
- rd_ack  in  1  arbiter accepts request this cycle.
- rd_done  in  1  pulse: last word of accepted burst written into FIFO.
- fifo_clr  out  1  one-cycle FIFO flush.
- rd_bank  out  1  buffer currently being read.
- underflow  out  1  sticky: data_req seen with FIFO empty.

Behaviour:
- Reset state: all outputs 0, FSM IDLE, addr = FRAME_BASE0, words_left = 0, swap_pend = 0, restart_pend = 0.
- Frame-start detect:
  - video_vs is registered once.
  - vs_fall = prev high AND current low.
  - Sets restart_pend.
- frame_done_wr sets swap_pend. Simultaneous clear-and-set is handled in CLR (below).
- FSM states: IDLE, CLR, CHECK, REQ, WAIT.
- IDLE:
  - If restart_pend -> CLR; otherwise stay.
- CLR (exactly one cycle):
  - fifo_clr = 1; underflow cleared; restart_pend cleared.
  - If swap_pend: toggle rd_bank and clear swap_pend. If frame_done_wr is asserted in this same cycle, swap_pend stays set.
  - addr = base of (new) rd_bank; words_left = H_DISP*V_DISP (21-bit, unsigned).
  - Next state: CHECK.
- CHECK:
  - If restart_pend -> CLR.
  - Else if words_left == 0 -> IDLE.
  - Else if fifo_level <= FIFO_DEPTH - BURST_LEN -> REQ, with rd_addr = addr and rd_len = min(BURST_LEN, words_left) registered on entry.
  - Else stay.
- REQ:
  - rd_req held high with rd_addr and rd_len stable until rd_ack.
  - On ack (same cycle): rd_req drops next cycle; addr += rd_len, wrapping mod 2^ADDR_W; words_left -= rd_len; -> WAIT.
  - No timeout; rd_ack outside REQ is ignored.
- WAIT:
  - On rd_done -> CHECK. restart_pend is honoured there, so an in-flight burst always completes before a flush.
  - rd_done outside WAIT is ignored.
- Outstanding bursts: at most one, so the level check needs no in-flight accounting.
- Latency:
  - vs_fall -> fifo_clr: 2 cycles from IDLE/CHECK.
  - CHECK pass -> rd_req: 1 cycle.
- underflow: set when data_req = 1 and fifo_level = 0 in any cycle except CLR; holds until the next CLR.
- Reset asserted mid-burst: immediate return to reset state. The arbiter sees rd_req fall, and the external burst is abandoned.
- Last burst: rd_len = remainder, e.g. 1024000 mod 64 = 0, so all bursts are 64. A non-multiple V_DISP/H_DISP yields a short final burst.

Test Plan:
- Reset, then vs_fall with fifo_level = 0 and rd_ack tied high one cycle after rd_req:
  - fifo_clr pulses once.
  - First rd_req at addr 0x000000, len 64.
  - After rd_done: second request at 0x000040.
- fifo_level = 449 in CHECK:
  - No rd_req.
  - Drop level to 448 -> rd_req next cycle.
- frame_done_wr pulse mid-frame, then next vs_fall:
  - rd_bank = 1; first rd_addr = 0x100000.
  - Another done pulse plus frame -> back to bank 0.
- vs_fall while in WAIT:
  - No fifo_clr until rd_done.
  - Then CHECK -> CLR; addr restarts at the bank base.
- Full frame (H_DISP = 100, V_DISP = 1, BURST_LEN = 64 override):
  - Bursts of 64 then 36.
  - FSM returns to IDLE; rd_req stays low.
- data_req with fifo_level = 0:
  - underflow = 1 and stays set.
  - Cleared by the fifo_clr cycle of the next frame.
- Async reset during REQ: rd_req low immediately; all outputs at their reset values.
